// File: rtl/wb_bus_if.sv
// Bridges one CPU SRAM-style port to a Wishbone B3 classic single-access master.
// Latency: bus request one cycle after cpu_ce_i; read data returned in the ack cycle.
// Backpressure: stallreq holds the pipeline while the access is outstanding.
//
// Optional feature macro: WB_BUS_IF_TIMEOUT_EN (ack timeout with sticky bus_err_o).
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   stall_i, flush_i      pipeline controller stall vector and flush
//   cpu_*_i / cpu_data_o  CPU-side request and returned read data
//   stallreq              stall request back to the controller
//   wb_*                  Wishbone classic master (all outputs registered)
//   bus_err_o             sticky ack-timeout flag (constant 0 without the macro)
module wb_bus_if #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall_i,
  input  logic          flush_i,
  input  logic          cpu_ce_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_data_i,
  input  logic          cpu_we_i,
  input  logic [3:0]    cpu_sel_i,
  output logic [DW-1:0] cpu_data_o,
  output logic          stallreq,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_stb_o,
  output logic          wb_cyc_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  output logic          bus_err_o
);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] rd_buf;
  logic          timeout_hit;

`ifdef WB_BUS_IF_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [TW-1:0] to_cnt;

  // Flush and ack both take priority over the timeout abort.
  assign timeout_hit = (state == BUSY) && !wb_ack_i && !flush_i &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Only BUSY is entered from IDLE, so holding the counter at zero outside
  // BUSY gives a clean start for every access.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != BUSY) begin
      to_cnt <= '0;
    end else if (!wb_ack_i) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_o <= 1'b0;
    end else if (timeout_hit) begin
      bus_err_o <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  // No timeout hardware: the comparison is constant false for any legal
  // TIMEOUT_CYCLES, so the flag is tied low.
  assign bus_err_o   = (TIMEOUT_CYCLES < 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_ce_i && !flush_i) state_nxt = BUSY;
      end
      BUSY: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (wb_ack_i) begin
          state_nxt = (stall_i != 6'd0) ? WAIT_FOR_STALL : IDLE;
        end else if (timeout_hit) begin
          state_nxt = WAIT_FOR_STALL;
        end
      end
      WAIT_FOR_STALL: begin
        if (flush_i || (stall_i == 6'd0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational CPU-side outputs; reset masks the request so the
  // controller never sees a stall while the block is being reset.
  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          stallreq = cpu_ce_i && !flush_i;
        end
        BUSY: begin
          if (wb_ack_i) begin
            cpu_data_o = wb_we_o ? '0 : wb_dat_i;
          end else if (!timeout_hit) begin
            stallreq = 1'b1;
          end
        end
        WAIT_FOR_STALL: begin
          cpu_data_o = rd_buf;
        end
        default: ;
      endcase
    end
  end

  // Registered Wishbone master outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 4'd0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_adr_o <= cpu_addr_i;
            // Write data only goes on the bus for writes.
            wb_dat_o <= cpu_we_i ? cpu_data_i : '0;
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
          end
        end
        BUSY: begin
          if (flush_i || wb_ack_i || timeout_hit) begin
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'd0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data held for the CPU while the pipeline stays stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_buf <= '0;
    end else if (state == BUSY) begin
      if (flush_i || timeout_hit) begin
        rd_buf <= '0;
      end else if (wb_ack_i && !wb_we_o) begin
        rd_buf <= wb_dat_i;
      end
    end else if ((state == WAIT_FOR_STALL) && flush_i) begin
      rd_buf <= '0;
    end
  end

endmodule

// File: tb/tb_wb_bus_if.sv
module tb_wb_bus_if;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        bus_err_o;

  wb_bus_if #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rd;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int errors = 0;
  int checks = 0;

  // Flags from the stimulus side to the monitor
  bit exp_err  = 1'b0;
  bit to_mode  = 1'b0;
  bit end_req  = 1'b0;
  bit end_done = 1'b0;

  // Monitor-owned model state
  bit          hold = 1'b0;
  logic [31:0] last_rd = '0;
  bit          prev_cyc = 1'b0;
  int          to_cnt = 0;
  bit          to_seen = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    txn_t t;
    if (end_req && !end_done) begin
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      end_done = 1'b1;
    end
    if (to_mode) begin
      if (wb_cyc_o) begin
        to_cnt++;
        if (to_cnt == TO) chk("to_abort_out", {stallreq, cpu_data_o}, 64'd0);
        else              chk("to_busy_stall", 64'(stallreq), 64'd1);
      end else if (to_cnt > 0 && !to_seen) begin
        chk("to_busy_cycles", 64'(to_cnt), 64'(TO));
        chk("to_bus_err", 64'(bus_err_o), 64'd1);
        chk("to_bus_idle", {wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o}, 64'd0);
        to_seen = 1'b1;
      end
    end else if (rst) begin
      chk("rst_out", {stallreq, cpu_data_o}, 64'd0);
      exp_q.delete();
      hold = 1'b0;
      last_rd = '0;
    end else if (wb_cyc_o) begin
      if (!prev_cyc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 64'(exp_q.size()), 64'd1);
        end else begin
          t = exp_q[0];
          chk("req_ctrl", {wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}, {1'b1, t.we, t.sel, t.adr});
          chk("req_dat", 64'(wb_dat_o), 64'(t.dat));
        end
      end
      if (flush_i) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        hold = 1'b0;
        last_rd = '0;
      end else if (wb_ack_i) begin
        if (exp_q.size() == 0) begin
          chk("ack_no_txn", 64'(exp_q.size()), 64'd1);
        end else begin
          t = exp_q.pop_front();
          chk("ack_data", 64'(cpu_data_o), 64'(t.rd));
          chk("ack_stallreq", 64'(stallreq), 64'd0);
          if (!t.we) last_rd = t.rd;
          hold = (stall_i != 6'd0);
        end
      end else begin
        chk("busy_out", {stallreq, cpu_data_o}, {1'b1, 32'd0});
      end
    end else if (hold) begin
      chk("hold_out", {stallreq, cpu_data_o}, {1'b0, last_rd});
      chk("hold_bus", {wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}, 64'd0);
      if (flush_i) begin
        hold = 1'b0;
        last_rd = '0;
      end else if (stall_i == 6'd0) begin
        hold = 1'b0;
      end
    end else begin
      chk("idle_out", {stallreq, cpu_data_o}, {cpu_ce_i && !flush_i, 32'd0});
      chk("idle_bus", {wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}, 64'd0);
      chk("idle_bus_dat", 64'(wb_dat_o), 64'd0);
      chk("bus_err", 64'(bus_err_o), 64'(exp_err));
    end
    prev_cyc = wb_cyc_o;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue a request, expected result from the reference memory, then play
  // the slave: ack after dly cycles, optionally hold stall for 'hold_n' cycles.
  task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int dly, input int hold_n,
                           input bit fl_wait);
    txn_t        t;
    logic [31:0] cur;
    cur = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    t.we = we; t.adr = a; t.dat = we ? d : 32'd0; t.sel = s;
    t.rd = we ? 32'd0 : cur;
    if (we) ref_mem[a] = merge(cur, d, s);
    exp_q.push_back(t);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d; cpu_sel_i = s;
    step();
    for (int i = 0; i < dly; i++) begin
      wb_dat_i = $urandom;
      step();
    end
    wb_ack_i = 1'b1;
    cur = slv_mem.exists(wb_adr_o) ? slv_mem[wb_adr_o] : init_word(wb_adr_o);
    if (wb_we_o) begin
      slv_mem[wb_adr_o] = merge(cur, wb_dat_o, wb_sel_o);
      wb_dat_i = $urandom;
    end else begin
      wb_dat_i = cur;
    end
    stall_i = (hold_n > 0) ? 6'b001111 : 6'd0;
    step();
    wb_ack_i = 1'b0;
    cpu_ce_i = 1'b0;
    wb_dat_i = $urandom;
    if (hold_n > 0) begin
      if (fl_wait) begin
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        stall_i = 6'd0;
      end else begin
        for (int i = 1; i < hold_n; i++) step();
        stall_i = 6'd0;
        step();
      end
    end
  endtask

  // mode 0: flush in 2nd BUSY cycle then a late ack; mode 1: flush with ack.
  task automatic flush_access(input int mode, input logic [31:0] a);
    txn_t t;
    t.we = 1'b0; t.adr = a; t.dat = 32'd0; t.sel = 4'hF; t.rd = 32'd0;
    exp_q.push_back(t);
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = a; cpu_sel_i = 4'hF;
    step();
    if (mode == 0) step();
    cpu_ce_i = 1'b0;
    flush_i = 1'b1;
    if (mode == 1) begin
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hFEED_F00D;
    end
    step();
    flush_i = 1'b0;
    wb_ack_i = 1'b0;
    if (mode == 0) begin
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hBAD0_BAD0;
      step();
      wb_ack_i = 1'b0;
    end
    step();
  endtask

  task automatic rand_burst(input int n);
    for (int k = 0; k < n; k++) begin
      bit hold_sel;
      hold_sel = ($urandom_range(0, 3) == 0);
      do_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
                4'($urandom_range(1, 15)), $urandom_range(0, 3),
                hold_sel ? $urandom_range(1, 3) : 0, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Directed read/write cases
    do_access(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0);
    do_access(1'b0, 32'h40, 32'h0, 4'hF, 3, 0, 1'b0);
    do_access(1'b1, 32'h100, 32'h1234_5678, 4'b0011, 1, 0, 1'b0);
    do_access(1'b0, 32'h100, 32'h0, 4'hF, 0, 0, 1'b0);
    do_access(1'b1, 32'h44, 32'hA5A5_A5A5, 4'hF, 0, 0, 1'b0);
    do_access(1'b0, 32'h44, 32'h0, 4'hF, 2, 4, 1'b0);
    // Write while stalled shows the previously read word
    do_access(1'b1, 32'h48, 32'h0BAD_CAFE, 4'hF, 0, 2, 1'b0);

    // Flush cases; each is followed by a held write exposing the buffer
    flush_access(0, 32'h40);
    do_access(1'b1, 32'h4C, 32'h1111_2222, 4'hF, 0, 2, 1'b0);
    do_access(1'b0, 32'h40, 32'h0, 4'hF, 1, 0, 1'b0);
    flush_access(1, 32'h40);
    do_access(1'b1, 32'h4C, 32'h3333_4444, 4'hF, 0, 2, 1'b0);
    do_access(1'b0, 32'h44, 32'h0, 4'hF, 0, 3, 1'b1);
    do_access(1'b1, 32'h4C, 32'h5555_6666, 4'hC, 0, 2, 1'b0);

    rand_burst(120);

    // Reset mid-access, with cpu_ce_i held high through the reset cycle
    begin
      txn_t t;
      t.we = 1'b0; t.adr = 32'h8; t.dat = 32'd0; t.sel = 4'hF; t.rd = 32'd0;
      exp_q.push_back(t);
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h8; cpu_sel_i = 4'hF;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      cpu_ce_i = 1'b0;
      step();
    end
    do_access(1'b0, 32'h40, 32'h0, 4'hF, 2, 0, 1'b0);

`ifdef WB_BUS_IF_TIMEOUT_EN
    to_mode = 1'b1;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80; cpu_sel_i = 4'hF;
    step();
    cpu_ce_i = 1'b0;
    repeat (TO + 3) step();
    to_mode = 1'b0;
    exp_err = 1'b1;
    step();
`endif

    rand_burst(30);

    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_done; i++) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
